seg_scan_driver: RTL

Parametrised multiplexed seven-segment driver for N-digit active-low displays. It takes a binary value and converts it to decimal with a sequential double-dabble, or shows it directly as hex. It scans the digits with an inter-digit blanking gap, and supports leading-zero blanking, per-digit decimal points and overflow indication. It sits between UART/counter datapaths and the board display pins.

---
 rtl/seg_scan_driver.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit active-low seven-segment driver: sequential binary-to-BCD
// or direct hex capture, leading-zero blanking, overflow dashes, gapped digit scan.
module seg_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int DATA_W    = 14,
    parameter int SCAN_DIV  = 50_000,
    parameter int BLANK_CYC = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    input  logic              hex_mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [DIGITS-1:0] cs,
    output logic [7:0]        dx,
    output logic              busy,
    output logic              ovf
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] DEC_LIMIT = pow10(DIGITS);

    // Active-low segments g..a, decimal point excluded.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, HEX, COMMIT} state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   sh_reg;
    logic [BCD_W-1:0]    bcd_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                op_blz_reg, op_ovf_reg;
    logic                pend_valid_reg, pend_hex_reg, pend_blz_reg;
    logic [DATA_W-1:0]   pend_data_reg;
    logic [BCD_W-1:0]    disp_reg;
    logic                lz_reg, ovf_reg;
    logic [PRE_W-1:0]    presc_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [DIGITS-1:0]   cs_reg;
    logic [7:0]          dx_reg;

    // A load arriving during COMMIT is newer than the pending slot, so it wins.
    logic [DATA_W-1:0]   req_data;
    logic                req_hex, req_blz, req_ovf, start_req;
    logic [63:0]         req_ext;

    always_comb begin
        req_data = pend_data_reg;
        req_hex  = pend_hex_reg;
        req_blz  = pend_blz_reg;
        if (load) begin
            req_data = data;
            req_hex  = hex_mode;
            req_blz  = blank_lz;
        end
    end

    assign req_ext   = 64'(req_data);
    assign req_ovf   = req_hex ? ((req_ext >> BCD_W) != 64'd0) : (req_ext >= DEC_LIMIT);
    assign start_req = ((state_reg == IDLE) && load) ||
                       ((state_reg == COMMIT) && (load || pend_valid_reg));

    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] hex_nib;
    genvar gi;

    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end

    if (DATA_W >= BCD_W) begin : g_hex_trunc
        assign hex_nib = sh_reg[BCD_W-1:0];
    end else begin : g_hex_ext
        assign hex_nib = {{(BCD_W-DATA_W){1'b0}}, sh_reg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // CONV stays one cycle past the last iteration before committing.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_req) state_next = req_hex ? HEX : CONV;
            CONV:    if (cnt_reg == CNT_W'(DATA_W)) state_next = COMMIT;
            HEX:     state_next = COMMIT;
            COMMIT:  state_next = start_req ? (req_hex ? HEX : CONV) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    // Carry out of the top BCD digit only happens for out-of-range values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_reg     <= '0;
            bcd_reg    <= '0;
            cnt_reg    <= '0;
            op_blz_reg <= 1'b0;
            op_ovf_reg <= 1'b0;
        end else if (start_req) begin
            sh_reg     <= req_data;
            bcd_reg    <= '0;
            cnt_reg    <= '0;
            op_blz_reg <= req_blz;
            op_ovf_reg <= req_ovf;
        end else if ((state_reg == CONV) && (cnt_reg != CNT_W'(DATA_W))) begin
            bcd_reg    <= {bcd_adj[BCD_W-2:0], sh_reg[DATA_W-1]};
            sh_reg     <= sh_reg << 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
            op_ovf_reg <= op_ovf_reg | bcd_adj[BCD_W-1];
        end else if (state_reg == HEX) begin
            bcd_reg    <= hex_nib;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_reg <= 1'b0;
            pend_hex_reg   <= 1'b0;
            pend_blz_reg   <= 1'b0;
            pend_data_reg  <= '0;
        end else if (state_reg == COMMIT) begin
            pend_valid_reg <= 1'b0;
        end else if (load && (state_reg != IDLE)) begin
            pend_valid_reg <= 1'b1;
            pend_hex_reg   <= hex_mode;
            pend_blz_reg   <= blank_lz;
            pend_data_reg  <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_reg <= '0;
            lz_reg   <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (state_reg == COMMIT) begin
            disp_reg <= bcd_reg;
            lz_reg   <= op_blz_reg;
            ovf_reg  <= op_ovf_reg;
        end
    end

    logic [DIGITS-1:0][6:0] seg_vec;
    logic [DIGITS-1:0]      lz_hide;

    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
        if (gi == 0) begin : g_lsd
            assign lz_hide[gi] = 1'b0;
        end else begin : g_upper
            assign lz_hide[gi] = lz_reg && (disp_reg[BCD_W-1:4*gi] == '0);
        end
        assign seg_vec[gi] = ovf_reg ? 7'h3F :
                             (lz_hide[gi] ? 7'h7F : seg7(disp_reg[4*gi +: 4]));
    end

    logic in_blank;
    if (BLANK_CYC > 0) begin : g_gap
        assign in_blank = (presc_reg < PRE_W'(BLANK_CYC));
    end else begin : g_nogap
        assign in_blank = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            idx_reg   <= '0;
            cs_reg    <= '1;
            dx_reg    <= 8'hFF;
        end else begin
            if (presc_reg == PRE_W'(SCAN_DIV - 1)) begin
                presc_reg <= '0;
                idx_reg   <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
            end else begin
                presc_reg <= presc_reg + PRE_W'(1);
            end
            if (in_blank) begin
                cs_reg <= '1;
                dx_reg <= 8'hFF;
            end else begin
                cs_reg <= ~(DIGITS'(1) << idx_reg);
                dx_reg <= {~dp_mask[idx_reg], seg_vec[idx_reg]};
            end
        end
    end

    assign cs  = cs_reg;
    assign dx  = dx_reg;
    assign ovf = ovf_reg;

endmodule
